mips_ni_ctrl: RTL

Controller that sequences traffic between the pipelined MIPS core and its NoC router port. It buffers outgoing send-instruction words in a small TX FIFO and presents them to the router with a valid/ready handshake. It also holds one incoming word, serves receive instructions, and issues a global pipeline stall whenever a send or receive instruction in the Execute stage cannot complete this cycle.

---
 rtl/mips_ni_pkg.sv | 20 ++
 rtl/ni_tx_fifo.sv | 64 ++++++
 rtl/mips_ni_ctrl.sv | 129 ++++++++++++
 3 files changed

// File: rtl/mips_ni_pkg.sv
// Shared types and sizing helpers for the MIPS network-interface controller.
package mips_ni_pkg;

    typedef enum logic [1:0] {
        RX_IDLE    = 2'd0,
        RX_WAIT    = 2'd1,
        RX_DELIVER = 2'd2
    } rx_state_t;

    localparam int DATA_W_DFLT = 32;
    localparam int ADDR_W_DFLT = 2;
    localparam int DEPTH_DFLT  = 4;
    localparam int FLIT_W      = ADDR_W_DFLT + DATA_W_DFLT;

    // Occupancy counter must represent 0..depth inclusive.
    function automatic int tx_cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/ni_tx_fifo.sv
// Synchronous FIFO holding outgoing {dest, payload} flits; pointers wrap modulo DEPTH.
module ni_tx_fifo
    import mips_ni_pkg::*;
#(
    parameter int WIDTH = FLIT_W,
    parameter int DEPTH = DEPTH_DFLT,
    localparam int CNT_W = tx_cnt_w(DEPTH),
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full      = (count_r == CNT_W'(DEPTH));
    assign empty     = (count_r == {CNT_W{1'b0}});
    assign count     = count_r;
    assign dout      = mem_r[rd_ptr_r];
    // Guards keep the state consistent even if a caller misuses push/pop.
    assign push_ok_s = push && !full;
    assign pop_ok_s  = pop && !empty;

    // Storage write; contents are not cleared on reset, the count gates visibility.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Pointer and occupancy tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/mips_ni_ctrl.sv
// NoC interface controller: TX FIFO toward the router, single-word RX buffer,
// and the receive FSM that stalls the pipeline until send/receive can complete.
module mips_ni_ctrl
    import mips_ni_pkg::*;
#(
    parameter int DATA_W = DATA_W_DFLT,
    parameter int ADDR_W = ADDR_W_DFLT,
    parameter int DEPTH  = DEPTH_DFLT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     proc_valid_E,
    input  logic [ADDR_W-1:0]        dest_add_E,
    input  logic [DATA_W-1:0]        NI_in,
    input  logic                     proc_ready_in_E,
    output logic                     stall,
    output logic                     data_valid,
    output logic [DATA_W-1:0]        wd_NI,
    output logic                     tx_valid,
    output logic [ADDR_W+DATA_W-1:0] tx_flit,
    input  logic                     tx_ready,
    input  logic                     rx_valid,
    input  logic [DATA_W-1:0]        rx_data,
    output logic                     rx_ready
);

    localparam int FW    = ADDR_W + DATA_W;
    localparam int CNT_W = tx_cnt_w(DEPTH);

    rx_state_t         state_r;
    rx_state_t         state_nxt_s;
    logic              buf_full_r;
    logic [DATA_W-1:0] rx_buf_r;
    logic              capture_s;
    logic              tx_full_s;
    logic              tx_empty_s;
    logic [CNT_W-1:0]  tx_count_s;
    logic [FW-1:0]     tx_head_s;
    logic              push_s;
    logic              pop_s;

    // Held send instructions push only once: on the cycle stall releases.
    assign push_s = proc_valid_E && !stall;
    assign pop_s  = tx_valid && tx_ready;

    ni_tx_fifo #(
        .WIDTH (FW),
        .DEPTH (DEPTH)
    ) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_s),
        .din   ({dest_add_E, NI_in}),
        .pop   (pop_s),
        .dout  (tx_head_s),
        .full  (tx_full_s),
        .empty (tx_empty_s),
        .count (tx_count_s)
    );

    assign tx_valid  = !rst && !tx_empty_s && (tx_count_s != {CNT_W{1'b0}});
    assign tx_flit   = tx_valid ? tx_head_s : {FW{1'b0}};
    assign rx_ready  = !buf_full_r && !rst;
    assign capture_s = rx_valid && rx_ready;

    // Stall depends only on state, FIFO fullness and Execute-stage requests.
    assign stall = !rst && ((proc_valid_E && tx_full_s)
                            || (state_r == RX_WAIT)
                            || (state_r == RX_IDLE && proc_ready_in_E));

    // Single-entry receive buffer; freed at the end of the delivery cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            buf_full_r <= 1'b0;
            rx_buf_r   <= {DATA_W{1'b0}};
        end else if (capture_s) begin
            buf_full_r <= 1'b1;
            rx_buf_r   <= rx_data;
        end else if (state_r == RX_DELIVER) begin
            buf_full_r <= 1'b0;
        end
    end

    // Receive FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= RX_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Receive FSM next state; a capture in RX_WAIT moves straight to delivery.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            RX_IDLE: begin
                if (proc_ready_in_E) begin
                    state_nxt_s = buf_full_r ? RX_DELIVER : RX_WAIT;
                end else begin
                    state_nxt_s = RX_IDLE;
                end
            end
            RX_WAIT: begin
                if (buf_full_r || capture_s) begin
                    state_nxt_s = RX_DELIVER;
                end else begin
                    state_nxt_s = RX_WAIT;
                end
            end
            RX_DELIVER: state_nxt_s = RX_IDLE;
            default:    state_nxt_s = RX_IDLE;
        endcase
    end

    // Register-file write port for the received word.
    always_comb begin
        data_valid = 1'b0;
        wd_NI      = {DATA_W{1'b0}};
        if (!rst && state_r == RX_DELIVER) begin
            data_valid = 1'b1;
            wd_NI      = rx_buf_r;
        end else begin
            data_valid = 1'b0;
            wd_NI      = {DATA_W{1'b0}};
        end
    end

endmodule
